// File: rtl/victim_cache_param.sv
// victim_cache_param: fully-associative exclusive victim cache with LRU replacement and 2-cycle pipelined lookup
// Optional write-back support is enabled by defining VC_WRITEBACK_EN.
// Ports:
//   clk, reset (async, active-low)
//   req_valid, page_offset        lookup request (cycle 0)
//   phys_tag_ret, tlb_miss        TLB result for the lookup in S1 (cycle 1)
//   ins_valid/ins_ready, ins_tag, ins_index, ins_data   line insert from L1
//   resp_valid, resp_hit, resp_byte, resp_line          lookup result (cycle 2)
//   VC_WRITEBACK_EN: ins_dirty, resp_dirty, evict_valid, evict_tag, evict_index, evict_data
module victim_cache_param #(
  parameter int ENTRIES     = 8,
  parameter int TAG_BITS    = 44,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 6,
  parameter int LINE_BITS   = 512
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic [INDEX_BITS+OFFSET_BITS-1:0] page_offset,
  input  logic [TAG_BITS-1:0]               phys_tag_ret,
  input  logic                              tlb_miss,
  input  logic                              ins_valid,
  output logic                              ins_ready,
  input  logic [TAG_BITS-1:0]               ins_tag,
  input  logic [INDEX_BITS-1:0]             ins_index,
  input  logic [LINE_BITS-1:0]              ins_data,
`ifdef VC_WRITEBACK_EN
  input  logic                              ins_dirty,
  output logic                              resp_dirty,
  output logic                              evict_valid,
  output logic [TAG_BITS-1:0]               evict_tag,
  output logic [INDEX_BITS-1:0]             evict_index,
  output logic [LINE_BITS-1:0]              evict_data,
`endif
  output logic                              resp_valid,
  output logic                              resp_hit,
  output logic [7:0]                        resp_byte,
  output logic [LINE_BITS-1:0]              resp_line
);
  localparam int AW = $clog2(ENTRIES);
  logic                              s1_valid;
  logic [INDEX_BITS+OFFSET_BITS-1:0] s1_off;
  logic [ENTRIES-1:0]                valid;
  logic [ENTRIES-1:0]                match;
  logic [AW-1:0]                     age    [ENTRIES];
  logic [TAG_BITS-1:0]               tag_q  [ENTRIES];
  logic [INDEX_BITS-1:0]             idx_q  [ENTRIES];
  logic [LINE_BITS-1:0]              data_q [ENTRIES];
`ifdef VC_WRITEBACK_EN
  logic [ENTRIES-1:0]                dirty;
`endif
  logic                              hit, accept, dup_found, inv_found;
  logic [AW-1:0]                     hit_sel, dup_sel, inv_sel, lru_sel, ins_sel;
  logic [LINE_BITS-1:0]              hit_line;
  // descending scan so the lowest-numbered invalid entry wins
  always_comb begin
    match     = '0;
    hit_sel   = '0;
    dup_sel   = '0;
    inv_sel   = '0;
    lru_sel   = '0;
    dup_found = 1'b0;
    inv_found = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      match[i] = valid[i] && tag_q[i] == phys_tag_ret && idx_q[i] == s1_off[OFFSET_BITS +: INDEX_BITS];
      if (match[i]) hit_sel = AW'(i);
      if (valid[i] && tag_q[i] == ins_tag && idx_q[i] == ins_index) begin
        dup_found = 1'b1;
        dup_sel   = AW'(i);
      end
      if (!valid[i]) begin
        inv_found = 1'b1;
        inv_sel   = AW'(i);
      end
      if (age[i] == AW'(ENTRIES - 1)) lru_sel = AW'(i);
    end
  end
  assign hit       = s1_valid && !tlb_miss && |match;
  assign ins_ready = !s1_valid;
  assign accept    = ins_valid && ins_ready;
  assign ins_sel   = dup_found ? dup_sel : inv_found ? inv_sel : lru_sel;
  assign hit_line  = data_q[hit_sel];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_off     <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_byte  <= '0;
      resp_line  <= '0;
`ifdef VC_WRITEBACK_EN
      resp_dirty <= 1'b0;
`endif
    end else begin
      s1_valid   <= req_valid;
      s1_off     <= page_offset;
      resp_valid <= s1_valid;
      resp_hit   <= hit;
      resp_byte  <= hit ? hit_line[{s1_off[OFFSET_BITS-1:0], 3'b000} +: 8] : '0;
      resp_line  <= hit ? hit_line : '0;
`ifdef VC_WRITEBACK_EN
      resp_dirty <= hit && dirty[hit_sel];
`endif
    end
  end
  // hit and insert never coincide: inserts are blocked while S1 holds a lookup
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) age[i] <= AW'(i);
`ifdef VC_WRITEBACK_EN
      dirty       <= '0;
      evict_valid <= 1'b0;
      evict_tag   <= '0;
      evict_index <= '0;
      evict_data  <= '0;
`endif
    end else begin
`ifdef VC_WRITEBACK_EN
      evict_valid <= 1'b0;
`endif
      if (hit) begin
        valid[hit_sel] <= 1'b0;
        for (int i = 0; i < ENTRIES; i++) if (age[i] > age[hit_sel]) age[i] <= age[i] - 1'b1;
        age[hit_sel] <= AW'(ENTRIES - 1);
      end else if (accept) begin
        valid[ins_sel] <= 1'b1;
        for (int i = 0; i < ENTRIES; i++) if (age[i] < age[ins_sel]) age[i] <= age[i] + 1'b1;
        age[ins_sel] <= '0;
`ifdef VC_WRITEBACK_EN
        dirty[ins_sel] <= ins_dirty | (dup_found & dirty[ins_sel]);
        if (!dup_found && !inv_found && dirty[ins_sel]) begin
          evict_valid <= 1'b1;
          evict_tag   <= tag_q[ins_sel];
          evict_index <= idx_q[ins_sel];
          evict_data  <= data_q[ins_sel];
        end
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[ins_sel]  <= ins_tag;
      idx_q[ins_sel]  <= ins_index;
      data_q[ins_sel] <= ins_data;
    end
  end
endmodule
